// File: rtl/divider.sv
// ============================================================================
// Module      : divider
// Description : Iterative radix-2 restoring divider, signed or unsigned per op.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int              CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;

    logic             r_sign;
    logic             r_dneg;
    logic             r_vneg;
    logic             r_zero;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_vmag;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_qfix;
    logic [WIDTH-1:0] w_rfix;

    assign w_dvd_mag = (sign && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
    assign w_dvs_mag = (sign && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;

    // r_q starts as the dividend magnitude and is shifted out MSB first while
    // quotient bits enter at the LSB, so it ends holding the quotient magnitude.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_vmag});
    assign w_sub   = w_shift[WIDTH-1:0] - r_vmag;

    assign w_qfix = (r_sign && (r_dneg ^ r_vneg)) ? (WIDTH'(0) - r_q)   : r_q;
    assign w_rfix = (r_sign && r_dneg)            ? (WIDTH'(0) - r_rem) : r_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (divisor == '0) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == C_LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sign      <= 1'b0;
            r_dneg      <= 1'b0;
            r_vneg      <= 1'b0;
            r_zero      <= 1'b0;
            r_dvd       <= '0;
            r_q         <= '0;
            r_vmag      <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign <= sign;
                        r_dneg <= dividend[WIDTH-1];
                        r_vneg <= divisor[WIDTH-1];
                        r_zero <= (divisor == '0);
                        r_dvd  <= dividend;
                        r_q    <= w_dvd_mag;
                        r_vmag <= w_dvs_mag;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (r_zero) begin
                        quotient    <= '1;
                        remainder   <= r_dvd;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= w_qfix;
                        remainder   <= w_rfix;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ============================================================================
// Module      : tb_divider
// Description : Scoreboard bench for divider with directed, hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             z;
        int               cyc;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    int   cyc;

    divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sign        (sign),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".quotient"},  32'(quotient),    32'(e.q));
                check({e.name, ".remainder"}, 32'(remainder),   32'(e.r));
                check({e.name, ".dbz"},       32'(div_by_zero), 32'(e.z));
                check({e.name, ".cycle"},     32'(cyc),         32'(e.cyc));
                check({e.name, ".busy"},      32'(busy),        32'd0);
            end
        end
    end

    task automatic issue(input string name, input logic s, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] eq,
                         input logic [WIDTH-1:0] er, input logic ez, input int lat);
        exp_t e;
        start    = 1'b1;
        sign     = s;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'h5A;
        divisor  = 8'h00;
        sign     = ~s;
        e.q = eq; e.r = er; e.z = ez; e.cyc = cyc + lat; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: got no done in 40 cycles, required done", name);
            sb.delete();
        end
    endtask

    task automatic run(input string name, input logic s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] eq,
                       input logic [WIDTH-1:0] er, input logic ez, input int lat);
        issue(name, s, a, b, eq, er, ez, lat);
        wait_idle(name);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        sign     = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.quotient",  32'(quotient),    32'd0);
        check("reset.remainder", 32'(remainder),   32'd0);
        check("reset.dbz",       32'(div_by_zero), 32'd0);
        check("reset.busy",      32'(busy),        32'd0);
        check("reset.done",      32'(done),        32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;

        run("u42_7",   1'b0, 8'd42,  8'd7,   8'd6,   8'd0,   1'b0, 9);
        run("u200_7",  1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9);
        run("sm42_7",  1'b1, 8'hD6,  8'd7,   8'hFA,  8'd0,   1'b0, 9);
        run("s7_m42",  1'b1, 8'd7,   8'hD6,  8'd0,   8'd7,   1'b0, 9);
        run("sm43_7",  1'b1, 8'hD5,  8'd7,   8'hFA,  8'hFF,  1'b0, 9);
        run("s43_m7",  1'b1, 8'd43,  8'hF9,  8'hFA,  8'd1,   1'b0, 9);
        run("s_ovf",   1'b1, 8'h80,  8'hFF,  8'h80,  8'd0,   1'b0, 9);
        run("u200_s0", 1'b1, 8'd200, 8'd1,   8'd200, 8'd0,   1'b0, 9);
        run("dbz5_0",  1'b0, 8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1);
        run("u10_3",   1'b0, 8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 9);

        // Second request arrives mid-operation and must be dropped.
        issue("busy42_7", 1'b0, 8'd42, 8'd7, 8'd6, 8'd0, 1'b0, 9);
        repeat (3) @(posedge clk);
        #1;
        check("busy.during_op", 32'(busy), 32'd1);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("busy42_7");
        repeat (14) @(negedge clk);

        // Abort 100/9 with an asynchronous reset mid-flight.
        start    = 1'b1;
        sign     = 1'b0;
        dividend = 8'd100;
        divisor  = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort.quotient",  32'(quotient),    32'd0);
        check("abort.remainder", 32'(remainder),   32'd0);
        check("abort.busy",      32'(busy),        32'd0);
        check("abort.done",      32'(done),        32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        run("u100_9", 1'b0, 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 9);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
